// File: rtl/snake_pkg.sv
// Shared types, IR remote codes and small helpers for the snake game controller.
package snake_pkg;

  typedef enum logic [2:0] {ST_START, ST_COUNTDOWN, ST_PLAY, ST_PAUSE, ST_OVER} state_t;
  typedef enum logic [1:0] {SCR_START, SCR_GAME, SCR_END} screen_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
  typedef enum logic [2:0] {
    CMD_NONE, CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT, CMD_ENTER, CMD_MENU
  } cmd_t;

  localparam logic [31:0] IR_UP    = 32'h20DF6A95;
  localparam logic [31:0] IR_DOWN  = 32'h20DFEA15;
  localparam logic [31:0] IR_LEFT  = 32'h20DF1AE5;
  localparam logic [31:0] IR_RIGHT = 32'h20DF9A65;
  localparam logic [31:0] IR_ENTER = 32'h20DF5AA5;
  localparam logic [31:0] IR_MENU  = 32'h20DFC23D;

  function automatic logic is_dir_cmd(cmd_t c);
    return (c == CMD_UP) || (c == CMD_DOWN) || (c == CMD_LEFT) || (c == CMD_RIGHT);
  endfunction

  function automatic dir_t cmd_dir(cmd_t c);
    case (c)
      CMD_UP:   return DIR_UP;
      CMD_DOWN: return DIR_DOWN;
      CMD_LEFT: return DIR_LEFT;
      default:  return DIR_RIGHT;
    endcase
  endfunction

  function automatic dir_t dir_reverse(dir_t d);
    case (d)
      DIR_UP:   return DIR_DOWN;
      DIR_DOWN: return DIR_UP;
      DIR_LEFT: return DIR_RIGHT;
      default:  return DIR_LEFT;
    endcase
  endfunction

  function automatic screen_t screen_of(state_t s);
    case (s)
      ST_START: return SCR_START;
      ST_OVER:  return SCR_END;
      default:  return SCR_GAME;
    endcase
  endfunction

endpackage

// File: rtl/ir_cmd_decode.sv
// Registers a decoded IR word as a one-cycle command; idle cycles read CMD_NONE.
module ir_cmd_decode
  import snake_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] word,
  input  logic        word_valid,
  output cmd_t        cmd
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd <= CMD_NONE;
    end else if (word_valid) begin
      case (word)
        IR_UP:    cmd <= CMD_UP;
        IR_DOWN:  cmd <= CMD_DOWN;
        IR_LEFT:  cmd <= CMD_LEFT;
        IR_RIGHT: cmd <= CMD_RIGHT;
        IR_ENTER: cmd <= CMD_ENTER;
        IR_MENU:  cmd <= CMD_MENU;
        default:  cmd <= CMD_NONE;
      endcase
    end else begin
      cmd <= CMD_NONE;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Snake game screen sequencer: IR command driven FSM, tick gating, direction
// filtering and score / high-score tracking. All outputs are registered.
module game_sequencer
  import snake_pkg::*;
#(
  parameter int COUNTDOWN_TICKS = 3,
  parameter int SCORE_PER_SEG   = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] word,
  input  logic        word_valid,
  input  logic        game_tick,
  input  logic        game_over,
  input  logic [7:0]  length,
  output screen_t     screen_sel,
  output logic        game_step,
  output logic        game_reset,
  output dir_t        dir_cmd,
  output logic        dir_valid,
  output logic        paused,
  output logic [1:0]  countdown,
  output logic [10:0] score,
  output logic [10:0] high_score
);

  cmd_t        cmd;
  state_t      state, state_d;
  logic        game_step_d, game_reset_d, dir_valid_d;
  dir_t        dir_d;
  logic [1:0]  countdown_d;
  logic [10:0] score_d, high_score_d, play_score;

  ir_cmd_decode u_ir_cmd_decode (
    .clk        (clk),
    .reset_n    (reset_n),
    .word       (word),
    .word_valid (word_valid),
    .cmd        (cmd)
  );

  assign play_score = 11'(length) * 11'(SCORE_PER_SEG);

  always_comb begin
    state_d      = state;
    game_step_d  = 1'b0;
    game_reset_d = 1'b0;
    dir_d        = dir_cmd;
    dir_valid_d  = 1'b0;
    countdown_d  = countdown;
    score_d      = score;
    high_score_d = high_score;

    case (state)
      ST_START, ST_OVER: begin
        if (cmd == CMD_ENTER) begin
          state_d      = ST_COUNTDOWN;
          game_reset_d = 1'b1;
          countdown_d  = 2'(COUNTDOWN_TICKS);
          dir_d        = DIR_RIGHT;
          score_d      = '0;
        end else if (cmd == CMD_MENU && state == ST_OVER) begin
          state_d = ST_START;
        end
      end

      ST_COUNTDOWN: begin
        if (cmd == CMD_MENU) begin
          state_d = ST_START;
        end else if (game_tick) begin
          if (countdown <= 2'd1) begin
            countdown_d = '0;
            state_d     = ST_PLAY;
          end else begin
            countdown_d = countdown - 2'd1;
          end
        end
      end

      ST_PLAY: begin
        score_d = play_score;
        // Collision outranks the tick and any command landing in the same cycle;
        // the high score is settled on the transition so it is valid on entry to OVER.
        if (game_over) begin
          state_d = ST_OVER;
          if (play_score > high_score) high_score_d = play_score;
        end else begin
          game_step_d = game_tick;
          if (cmd == CMD_ENTER) begin
            state_d = ST_PAUSE;
          end else if (cmd == CMD_MENU) begin
            state_d = ST_START;
          end else if (is_dir_cmd(cmd) && cmd_dir(cmd) != dir_cmd &&
                       cmd_dir(cmd) != dir_reverse(dir_cmd)) begin
            dir_d       = cmd_dir(cmd);
            dir_valid_d = 1'b1;
          end
        end
      end

      ST_PAUSE: begin
        if (cmd == CMD_ENTER)     state_d = ST_PLAY;
        else if (cmd == CMD_MENU) state_d = ST_START;
      end

      default: state_d = ST_START;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_START;
      screen_sel <= SCR_START;
      game_step  <= 1'b0;
      game_reset <= 1'b0;
      dir_cmd    <= DIR_RIGHT;
      dir_valid  <= 1'b0;
      paused     <= 1'b0;
      countdown  <= '0;
      score      <= '0;
      high_score <= '0;
    end else begin
      state      <= state_d;
      screen_sel <= screen_of(state_d);
      game_step  <= game_step_d;
      game_reset <= game_reset_d;
      dir_cmd    <= dir_d;
      dir_valid  <= dir_valid_d;
      paused     <= (state_d == ST_PAUSE);
      countdown  <= countdown_d;
      score      <= score_d;
      high_score <= high_score_d;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer.
module tb_game_sequencer;
  import snake_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] word = '0;
  logic        word_valid = 1'b0;
  logic        game_tick = 1'b0;
  logic        game_over = 1'b0;
  logic [7:0]  length = 8'd12;
  screen_t     screen_sel;
  logic        game_step, game_reset, dir_valid, paused;
  dir_t        dir_cmd;
  logic [1:0]  countdown;
  logic [10:0] score, high_score;

  int checks = 0;
  int errors = 0;

  game_sequencer #(.COUNTDOWN_TICKS(3), .SCORE_PER_SEG(5)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .word       (word),
    .word_valid (word_valid),
    .game_tick  (game_tick),
    .game_over  (game_over),
    .length     (length),
    .screen_sel (screen_sel),
    .game_step  (game_step),
    .game_reset (game_reset),
    .dir_cmd    (dir_cmd),
    .dir_valid  (dir_valid),
    .paused     (paused),
    .countdown  (countdown),
    .score      (score),
    .high_score (high_score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // After return the FSM has acted on the decoded command.
  task automatic send(input logic [31:0] code);
    word = code; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    step();
  endtask

  task automatic tick();
    game_tick = 1'b1;
    step();
    game_tick = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_screen"}, 32'(screen_sel), 32'(SCR_START));
    check({tag, "_step"},   32'(game_step), 0);
    check({tag, "_greset"}, 32'(game_reset), 0);
    check({tag, "_dir"},    32'(dir_cmd), 32'(DIR_RIGHT));
    check({tag, "_dvalid"}, 32'(dir_valid), 0);
    check({tag, "_paused"}, 32'(paused), 0);
    check({tag, "_cd"},     32'(countdown), 0);
    check({tag, "_score"},  32'(score), 0);
    check({tag, "_high"},   32'(high_score), 0);
  endtask

  initial begin
    step(2);
    check_reset_vals("rst");
    reset_n = 1'b1;
    step();

    send(32'h12345678);
    check("unk_start_screen", 32'(screen_sel), 32'(SCR_START));
    check("unk_start_greset", 32'(game_reset), 0);

    // Start a game: reset pulse two clocks after word_valid.
    send(IR_ENTER);
    check("enter_greset", 32'(game_reset), 1);
    check("enter_screen", 32'(screen_sel), 32'(SCR_GAME));
    check("enter_cd", 32'(countdown), 3);
    check("enter_dvalid", 32'(dir_valid), 0);
    step();
    check("enter_greset_end", 32'(game_reset), 0);

    tick(); check("cd2", 32'(countdown), 2);
    tick(); check("cd1", 32'(countdown), 1);
    tick(); check("cd0", 32'(countdown), 0);
    check("cd0_nostep", 32'(game_step), 0);
    tick();
    check("first_step", 32'(game_step), 1);
    check("play_score", 32'(score), 60);
    step();
    check("step_end", 32'(game_step), 0);

    // Direction filter.
    send(IR_LEFT);
    check("rev_dvalid", 32'(dir_valid), 0);
    check("rev_dir", 32'(dir_cmd), 32'(DIR_RIGHT));
    send(IR_UP);
    check("up_dvalid", 32'(dir_valid), 1);
    check("up_dir", 32'(dir_cmd), 32'(DIR_UP));
    step();
    check("up_dvalid_end", 32'(dir_valid), 0);
    send(IR_UP);
    check("same_dvalid", 32'(dir_valid), 0);
    send(IR_DOWN);
    check("down_rev_dir", 32'(dir_cmd), 32'(DIR_UP));
    send(32'h12345678);
    check("unk_play_dir", 32'(dir_cmd), 32'(DIR_UP));
    check("unk_play_paused", 32'(paused), 0);

    // Pause and resume.
    send(IR_ENTER);
    check("pause_paused", 32'(paused), 1);
    check("pause_screen", 32'(screen_sel), 32'(SCR_GAME));
    tick();
    check("pause_nostep", 32'(game_step), 0);
    send(IR_LEFT);
    check("pause_dir", 32'(dir_cmd), 32'(DIR_UP));
    check("pause_dvalid", 32'(dir_valid), 0);
    send(IR_ENTER);
    check("resume_paused", 32'(paused), 0);
    check("resume_dir", 32'(dir_cmd), 32'(DIR_UP));
    tick();
    check("resume_step", 32'(game_step), 1);

    // game_over with tick and ENTER decode in the same cycle.
    word = IR_ENTER; word_valid = 1'b1;
    step();
    word_valid = 1'b0; game_over = 1'b1; game_tick = 1'b1;
    step();
    game_tick = 1'b0;
    check("over_screen", 32'(screen_sel), 32'(SCR_END));
    check("over_nostep", 32'(game_step), 0);
    check("over_paused", 32'(paused), 0);
    check("over_score", 32'(score), 60);
    check("over_high", 32'(high_score), 60);
    step(2);
    check("over_hold", 32'(screen_sel), 32'(SCR_END));

    // Replay with a shorter snake: high score keeps 60.
    send(IR_ENTER);
    check("replay_greset", 32'(game_reset), 1);
    check("replay_score_clr", 32'(score), 0);
    check("replay_cd", 32'(countdown), 3);
    game_over = 1'b0; length = 8'd8;
    tick(); tick(); tick();
    step();
    check("replay_score", 32'(score), 40);
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    check("replay_over", 32'(screen_sel), 32'(SCR_END));
    check("replay_high", 32'(high_score), 60);

    // MENU beats a same-cycle tick in COUNTDOWN.
    send(IR_ENTER);
    tick();
    check("menu_cd_pre", 32'(countdown), 2);
    word = IR_MENU; word_valid = 1'b1;
    step();
    word_valid = 1'b0; game_tick = 1'b1;
    step();
    game_tick = 1'b0;
    check("menu_screen", 32'(screen_sel), 32'(SCR_START));
    check("menu_cd", 32'(countdown), 2);
    tick(); tick(); tick();
    check("menu_stay", 32'(screen_sel), 32'(SCR_START));
    check("menu_nostep", 32'(game_step), 0);

    // Asynchronous reset mid-game.
    send(IR_ENTER);
    tick(); tick(); tick();
    step();
    check("pre_rst_score", 32'(score), 40);
    reset_n = 1'b0;
    #2;
    check_reset_vals("async_rst");
    step();
    reset_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
